// File: rtl/syscall_unit.sv
// Syscall service unit: decodes v0/a0 on a syscall pulse, stalls the pipeline and
// streams print-int, print-char and NUL-terminated print-string output to the console.
module syscall_unit #(
  parameter int unsigned MAX_STR_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        int_valid,
  output logic [31:0] int_data,
  input  logic        out_ready,
  output logic        stall,
  output logic        halt,
  output logic        err,
  output logic        trunc
);

  localparam int unsigned CW = $clog2(MAX_STR_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INT_OUT,
    S_FETCH,
    S_EMIT,
    S_HALT
  } state_t;

  state_t        state;
  logic [31:0]   code;
  logic [31:0]   ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [7:0]    byte_r;
  logic [7:0]    fetched;
  logic          known;

  always_comb begin
    fetched = mem_rdata[7:0];
    case (ptr[1:0])
      2'd0: fetched = mem_rdata[7:0];
      2'd1: fetched = mem_rdata[15:8];
      2'd2: fetched = mem_rdata[23:16];
      2'd3: fetched = mem_rdata[31:24];
      default: fetched = mem_rdata[7:0];
    endcase
  end

  always_comb begin
    known = 1'b0;
    case (v0)
      32'd1, 32'd4, 32'd10, 32'd11: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  always_comb cnt_next = cnt + CW'(1);

  // Stall is combinational so the pipeline freezes in the very cycle the syscall is seen.
  always_comb begin
    mem_req    = (state == S_FETCH);
    char_valid = (state == S_EMIT);
    int_valid  = (state == S_INT_OUT);
    halt       = (state == S_HALT);
    char_data  = byte_r;
    mem_addr   = {ptr[31:2], 2'b00};
    stall      = !rst && ((state != S_IDLE) || (syscall && known));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      code     <= '0;
      ptr      <= '0;
      cnt      <= '0;
      byte_r   <= '0;
      int_data <= '0;
      err      <= 1'b0;
      trunc    <= 1'b0;
    end else begin
      err   <= 1'b0;
      trunc <= 1'b0;
      case (state)
        S_IDLE: begin
          if (syscall) begin
            code <= v0;
            case (v0)
              32'd1: begin
                int_data <= a0;
                state    <= S_INT_OUT;
              end
              32'd4: begin
                ptr   <= a0;
                cnt   <= '0;
                state <= S_FETCH;
              end
              32'd11: begin
                byte_r <= a0[7:0];
                state  <= S_EMIT;
              end
              32'd10: state <= S_HALT;
              default: err <= 1'b1;
            endcase
          end
        end
        S_INT_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        S_FETCH: begin
          if (mem_ack) begin
            byte_r <= fetched;
            state  <= (fetched == 8'h00) ? S_IDLE : S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            if (code == 32'd11) begin
              state <= S_IDLE;
            end else begin
              ptr <= ptr + 32'd1;
              cnt <= cnt_next;
              if (cnt_next == CW'(MAX_STR_LEN)) begin
                trunc <= 1'b1;
                state <= S_IDLE;
              end else begin
                state <= S_FETCH;
              end
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit (MAX_STR_LEN=4): char, int, string, backpressure,
// truncation with pointer wrap, reset abort, unknown code and exit.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst, syscall;
  logic [31:0] v0, a0;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        char_valid, int_valid, out_ready;
  logic [7:0]  char_data;
  logic [31:0] int_data;
  logic        stall, halt, err, trunc;

  int unsigned vectors = 0, miscompares = 0;
  int unsigned ack_delay = 0, rdy_delay = 0, req_cnt = 0, rdy_cnt = 0;
  int unsigned trunc_cnt = 0, err_cnt = 0, cv_cnt = 0;
  logic [7:0]  got[$];
  logic [31:0] addrs[$];
  logic        hold_c = 1'b0, hold_m = 1'b0;
  logic [7:0]  hold_d = '0;

  syscall_unit #(.MAX_STR_LEN(4)) dut (
    .clk(clk), .rst(rst), .syscall(syscall), .v0(v0), .a0(a0),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .char_valid(char_valid), .char_data(char_data),
    .int_valid(int_valid), .int_data(int_data), .out_ready(out_ready),
    .stall(stall), .halt(halt), .err(err), .trunc(trunc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h6948_0000;
      32'h0000_0104: return 32'h0000_0021;
      32'hFFFF_FFFC: return 32'h4443_4241;
      32'h0000_0000: return 32'h4847_4645;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory and console models with programmable wait/backpressure cycles.
  assign mem_rdata = mem_word(mem_addr);
  assign mem_ack   = mem_req && (req_cnt >= ack_delay);
  assign out_ready = (char_valid || int_valid) && (rdy_cnt >= rdy_delay);

  always @(posedge clk) begin
    req_cnt <= (mem_req && !mem_ack) ? req_cnt + 1 : 0;
    rdy_cnt <= ((char_valid || int_valid) && !out_ready) ? rdy_cnt + 1 : 0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      if (hold_c) chk("char_hold", {23'd0, char_valid, char_data}, {23'd0, 1'b1, hold_d});
      if (hold_m) chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
      if (char_valid && out_ready) got.push_back(char_data);
      if (mem_req && mem_ack) addrs.push_back(mem_addr);
      if (trunc) trunc_cnt++;
      if (err) err_cnt++;
      if (char_valid) cv_cnt++;
    end
    hold_c = !rst && char_valid && !out_ready;
    hold_d = char_data;
    hold_m = !rst && mem_req && !mem_ack;
  end

  task automatic do_call(input logic [31:0] code_i, input logic [31:0] arg_i,
                         output int unsigned n);
    @(negedge clk);
    v0 = code_i; a0 = arg_i; syscall = 1'b1;
    #1;
    n = 0;
    while (stall && n < 300) begin
      n++;
      @(negedge clk);
      syscall = 1'b0; v0 = 32'd0; a0 = 32'd0;
      #1;
    end
    syscall = 1'b0;
    if (n >= 300) chk("call_timeout", n, 32'd0);
  endtask

  task automatic chk_bytes(input string tag, input logic [31:0] exp_n,
                           input logic [31:0] packed_exp);
    chk({tag, "_count"}, 32'(got.size()), exp_n);
    for (int i = 0; i < int'(exp_n) && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got[i]}, {24'd0, packed_exp[8*i +: 8]});
  endtask

  initial begin
    int unsigned n;
    logic [31:0] exp_addr[4];

    rst = 1'b1; syscall = 1'b0; v0 = '0; a0 = '0;
    repeat (2) @(negedge clk);
    #1 chk("reset_outs", {25'd0, stall, mem_req, char_valid, int_valid, halt, err, trunc}, 32'd0);
    chk("reset_data", {char_data, mem_addr[23:0]}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Print char; v0/a0 changes after the sampling edge must not matter.
    got.delete();
    @(negedge clk); v0 = 32'd11; a0 = 32'h41; syscall = 1'b1;
    #1 chk("pc_stall_c0", {31'd0, stall}, 32'd1);
    @(negedge clk); syscall = 1'b0; v0 = 32'd0; a0 = 32'h99;
    #1 chk("pc_c1", {22'd0, stall, char_valid, char_data}, {22'd0, 1'b1, 1'b1, 8'h41});
    @(negedge clk);
    #1 chk("pc_c2_idle", {30'd0, stall, char_valid}, 32'd0);
    chk_bytes("pc", 32'd1, 32'h0000_0041);

    // Print int.
    @(negedge clk); v0 = 32'd1; a0 = 32'hDEAD_BEEF; syscall = 1'b1;
    #1 chk("pi_stall_c0", {31'd0, stall}, 32'd1);
    @(negedge clk); syscall = 1'b0; a0 = 32'd0;
    #1 chk("pi_valid", {30'd0, stall, int_valid}, 32'd3);
    chk("pi_data", int_data, 32'hDEAD_BEEF);
    @(negedge clk);
    #1 chk("pi_idle", {30'd0, stall, int_valid}, 32'd0);

    // Unaligned string, zero-wait.
    exp_addr = '{32'h100, 32'h100, 32'h104, 32'h104};
    got.delete(); addrs.delete(); trunc_cnt = 0;
    do_call(32'd4, 32'h102, n);
    chk("str_stall_cycles", n, 32'd8);
    repeat (2) @(negedge clk);
    chk_bytes("str", 32'd3, 32'h0021_6948);
    chk("str_fetches", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < addrs.size(); i++)
      chk($sformatf("str_addr%0d", i), addrs[i], exp_addr[i]);
    chk("str_no_trunc", trunc_cnt, 32'd0);

    // Same string with memory wait states and console backpressure.
    ack_delay = 3; rdy_delay = 2;
    got.delete(); addrs.delete();
    do_call(32'd4, 32'h102, n);
    chk("bp_stall_cycles", n, 32'd26);
    repeat (2) @(negedge clk);
    chk_bytes("bp", 32'd3, 32'h0021_6948);
    chk("bp_fetches", 32'(addrs.size()), 32'd4);
    ack_delay = 0; rdy_delay = 0;

    // Truncation at MAX_STR_LEN=4 with pointer wrap past 0xFFFFFFFF.
    exp_addr = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0};
    got.delete(); addrs.delete(); trunc_cnt = 0;
    do_call(32'd4, 32'hFFFF_FFFE, n);
    chk("tr_stall_cycles", n, 32'd9);
    repeat (3) @(negedge clk);
    #1 chk_bytes("tr", 32'd4, 32'h4645_4443);
    chk("tr_fetches", 32'(addrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < addrs.size(); i++)
      chk($sformatf("tr_addr%0d", i), addrs[i], exp_addr[i]);
    chk("tr_pulse_count", trunc_cnt, 32'd1);
    chk("tr_idle", {30'd0, mem_req, stall}, 32'd0);

    // Reset asserted while a character is being offered.
    rdy_delay = 5; got.delete();
    @(negedge clk); v0 = 32'd4; a0 = 32'h102; syscall = 1'b1;
    n = 0;
    do begin
      @(negedge clk); syscall = 1'b0; n++;
      #1;
    end while (!char_valid && n < 20);
    chk("rs_reached_emit", {31'd0, char_valid}, 32'd1);
    rst = 1'b1;
    #1 chk("rs_outs", {25'd0, stall, mem_req, char_valid, int_valid, halt, err, trunc}, 32'd0);
    chk("rs_data", {char_data, mem_addr[23:0]}, 32'd0);
    @(negedge clk); rst = 1'b0; cv_cnt = 0;
    repeat (6) @(negedge clk);
    chk("rs_no_char", cv_cnt, 32'd0);
    chk("rs_no_accept", 32'(got.size()), 32'd0);
    rdy_delay = 0;

    // Unknown code: err pulse, no stall.
    err_cnt = 0;
    @(negedge clk); v0 = 32'd7; a0 = 32'd0; syscall = 1'b1;
    #1 chk("unk_stall_c0", {31'd0, stall}, 32'd0);
    @(negedge clk); syscall = 1'b0;
    #1 chk("unk_c1", {30'd0, err, stall}, 32'd2);
    @(negedge clk);
    #1 chk("unk_c2", {30'd0, err, stall}, 32'd0);
    chk("unk_err_count", err_cnt, 32'd1);

    // Exit, then a later syscall is ignored.
    @(negedge clk); v0 = 32'd10; syscall = 1'b1;
    #1 chk("ex_stall_c0", {31'd0, stall}, 32'd1);
    @(negedge clk); syscall = 1'b0;
    #1 chk("ex_halt", {30'd0, halt, stall}, 32'd3);
    cv_cnt = 0;
    @(negedge clk); v0 = 32'd11; a0 = 32'h5A; syscall = 1'b1;
    @(negedge clk); syscall = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("ex_sticky", {29'd0, halt, stall, char_valid}, 32'd6);
    chk("ex_ignored", cv_cnt, 32'd0);
    rst = 1'b1;
    #1 chk("ex_reset_clears", {30'd0, halt, stall}, 32'd0);
    @(negedge clk); rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
